// File: rtl/t_state_sequencer.sv
// ---------------------------------------------------------------------------
// t_state_sequencer
//   Cycle sequencer for the 6502C control unit. Holds the one-hot T-state
//   counter, the latched opcode and the active instruction class, and applies
//   the cycle-count rules for normal, indexed-read (rmw), branch and interrupt
//   (RESET/NMI/IRQ/BRK) sequences. Its outputs drive the per-opcode control
//   table lookup; the final-cycle / index-cycle flags come back from it.
//
// Ports
//   phi1        in   system clock, all state changes on the rising edge
//   rst         in   asynchronous active-high reset
//   rdy         in   1 = advance, 0 = freeze (NMI edge detector keeps running)
//   opcode_in   in   data bus, captured in the T1 fetch cycle
//   iclass_in   in   classifier result for opcode_in (00 norm, 01 rmw, 10 branch)
//   status      in   P register (C0 Z1 I2 D3 V6 N7)
//   last_cyc    in   control table: current cycle is final (norm/rmw)
//   idx_cyc     in   control table: current cycle does the low-byte index add
//   page_cross  in   carry out of the low-byte address add
//   nmi_n       in   NMI, falling-edge triggered
//   irq_n       in   IRQ, level, masked by status[2]
//   currT       out  one-hot T-state (bit0 = T1)
//   opcode      out  latched opcode (00 during injected interrupts)
//   iclass      out  active class, 11 = interrupt sequence
//   sync        out  1 in the T1 opcode-fetch cycle
//   vec_sel     out  00 BRK/IRQ, 01 NMI, 11 RESET
//   br_taken    out  branch condition, valid from T2 of a branch until next T1
//   skip        out  one-cycle pulse after a skipped page-fix cycle
//   seq_err     out  sticky: a sequence ran past T_W without a final cycle
// ---------------------------------------------------------------------------
module t_state_sequencer #(
  parameter int T_W         = 7,
  parameter int INT_LEN     = 7,
  parameter bit RMW_SKIP_EN = 1'b1
) (
  input  logic           phi1,
  input  logic           rst,
  input  logic           rdy,
  input  logic [7:0]     opcode_in,
  input  logic [1:0]     iclass_in,
  input  logic [7:0]     status,
  input  logic           last_cyc,
  input  logic           idx_cyc,
  input  logic           page_cross,
  input  logic           nmi_n,
  input  logic           irq_n,
  output logic [T_W-1:0] currT,
  output logic [7:0]     opcode,
  output logic [1:0]     iclass,
  output logic           sync,
  output logic [1:0]     vec_sel,
  output logic           br_taken,
  output logic           skip,
  output logic           seq_err
);

  typedef enum logic [1:0] {
    CL_NORM   = 2'b00,
    CL_RMW    = 2'b01,
    CL_BRANCH = 2'b10,
    CL_INT    = 2'b11
  } cls_t;

  localparam logic [1:0]     VEC_BRK   = 2'b00;
  localparam logic [1:0]     VEC_NMI   = 2'b01;
  localparam logic [1:0]     VEC_RESET = 2'b11;
  localparam logic [T_W-1:0] T1_HOT    = {{(T_W-1){1'b0}}, 1'b1};

  cls_t           cls_q, cls_d;
  logic [T_W-1:0] t_d;
  logic [7:0]     op_d;
  logic           sync_d, brt_d, skip_d, err_d;
  logic [1:0]     vec_d;
  logic           nmi_pend, nmi_prev, pend_d, pend_clr, nmi_fell;
  logic           final_cyc, jump, taken, int_req;
  logic [2:0]     flag_idx;

  assign iclass = cls_q;

  // Branch flag select from opcode[7:6]: N, V, C, Z.
  always_comb begin
    flag_idx = 3'd7;
    unique case (opcode[7:6])
      2'b00: flag_idx = 3'd7;
      2'b01: flag_idx = 3'd6;
      2'b10: flag_idx = 3'd0;
      2'b11: flag_idx = 3'd1;
    endcase
  end

  assign taken    = (status[flag_idx] == opcode[5]);
  assign nmi_fell = nmi_prev & ~nmi_n;
  assign int_req  = nmi_pend | (~irq_n & ~status[2]);

  always_comb begin
    t_d       = currT;
    op_d      = opcode;
    cls_d     = cls_q;
    sync_d    = sync;
    vec_d     = vec_sel;
    brt_d     = br_taken;
    skip_d    = skip;
    err_d     = seq_err;
    pend_clr  = 1'b0;
    final_cyc = 1'b0;
    jump      = 1'b0;

    if (rdy) begin
      skip_d = 1'b0;
      if (sync) begin
        // Opcode fetch: BRK (00) is forced into the interrupt sequence.
        op_d   = opcode_in;
        sync_d = 1'b0;
        t_d    = currT << 1;
        if (opcode_in == 8'h00) begin
          cls_d = CL_INT;
          vec_d = VEC_BRK;
        end else begin
          cls_d = cls_t'(iclass_in);
        end
      end else begin
        unique case (cls_q)
          CL_NORM: final_cyc = last_cyc;
          CL_RMW: begin
            final_cyc = last_cyc;
            // The two-state jump is only legal while Tn+2 still exists.
            jump = RMW_SKIP_EN && idx_cyc && !page_cross && !last_cyc &&
                   (currT[T_W-1:T_W-2] == 2'b00);
          end
          CL_BRANCH: begin
            if (currT[1])      final_cyc = ~taken;
            else if (currT[2]) final_cyc = ~page_cross;
            else if (currT[3]) final_cyc = 1'b1;
          end
          CL_INT: final_cyc = currT[INT_LEN-1];
        endcase

        if (cls_q == CL_BRANCH && currT[1]) brt_d = taken;

        if (final_cyc) begin
          t_d   = T1_HOT;
          brt_d = 1'b0;
          if (int_req) begin
            sync_d = 1'b0;
            op_d   = 8'h00;
            cls_d  = CL_INT;
            vec_d  = nmi_pend ? VEC_NMI : VEC_BRK;
          end else begin
            sync_d = 1'b1;
          end
        end else if (currT[T_W-1]) begin
          t_d    = T1_HOT;
          sync_d = 1'b1;
          err_d  = 1'b1;
          brt_d  = 1'b0;
        end else if (jump) begin
          t_d    = currT << 2;
          skip_d = 1'b1;
        end else begin
          t_d = currT << 1;
        end

        // An NMI is consumed only by its own sequence, on the T4->T5 step.
        pend_clr = (cls_q == CL_INT) && (vec_sel == VEC_NMI) &&
                   currT[3] && !final_cyc;
      end
    end

    // A new edge always wins over a clear in the same cycle.
    pend_d = (nmi_pend & ~pend_clr) | nmi_fell;
  end

  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      currT    <= T1_HOT;
      opcode   <= 8'h00;
      cls_q    <= CL_INT;
      sync     <= 1'b0;
      vec_sel  <= VEC_RESET;
      br_taken <= 1'b0;
      skip     <= 1'b0;
      seq_err  <= 1'b0;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b1;
    end else begin
      currT    <= t_d;
      opcode   <= op_d;
      cls_q    <= cls_d;
      sync     <= sync_d;
      vec_sel  <= vec_d;
      br_taken <= brt_d;
      skip     <= skip_d;
      seq_err  <= err_d;
      nmi_pend <= pend_d;
      nmi_prev <= nmi_n;
    end
  end

endmodule
